// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: FSM states, display view select and opcode width for alu_op_sequencer
package alu_seq_pkg;
  localparam int OP_W = 4;
  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW} state_e;
  typedef enum logic [1:0] {V_F, V_A, V_B} view_e;
  function automatic view_e view_next(input view_e v);
    return v == V_F ? V_A : v == V_A ? V_B : V_F;
  endfunction
endpackage

// File: rtl/alu_op_sequencer_btn_debounce.sv
// btn_debounce: 2-flop sync, stable-level debounce, one-clk pulse on accepted press
//   clk, rst_n (async active-low), btn_i raw button, pulse_o one-clk press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q;
  logic level_q, pulse_q, accept;
  logic [CW-1:0] cnt_q;
  // the synced level must differ from the accepted level for DEBOUNCE_CYCLES consecutive clocks
  assign accept = (sync_q[1] != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign pulse_o = pulse_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= (sync_q[1] == level_q || accept) ? '0 : cnt_q + 1'b1;
      level_q <= accept ? sync_q[1] : level_q;
      pulse_q <= accept & sync_q[1];
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: button-driven operand/opcode entry for an external ALU, result capture and display
//   clk, rst_n (async active-low); sw switches (opcode in sw[3:0]); btn_step/btn_clr/btn_view raw buttons
//   alu_a/alu_b/alu_op registered ALU inputs; alu_f/alu_zf/alu_of ALU result and flags
//   disp_data/led registered display images; stage one-hot {OP,B,A}; busy high in EXEC
//   ALU_SEQ_FLAGS_EN: keep ZF/OF and show them on led[31:30] in SHOW
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int EXEC_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     sw,
  input  logic            btn_step,
  input  logic            btn_clr,
  input  logic            btn_view,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [31:0]     alu_f,
  input  logic            alu_zf,
  input  logic            alu_of,
  output logic [31:0]     disp_data,
  output logic [31:0]     led,
  output logic [2:0]      stage,
  output logic            busy
);
  state_e state_q, state_d;
  view_e view_q, view_d;
  logic [31:0] a_q, a_d, b_q, b_d, f_q, f_d, disp_q, disp_d, led_q, led_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic step_p, clr_p, view_p, last;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (.clk(clk), .rst_n(rst_n), .btn_i(btn_step), .pulse_o(step_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr  (.clk(clk), .rst_n(rst_n), .btn_i(btn_clr),  .pulse_o(clr_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_view (.clk(clk), .rst_n(rst_n), .btn_i(btn_view), .pulse_o(view_p));
`ifdef ALU_SEQ_FLAGS_EN
  logic zf_q, zf_d, of_q, of_d;
`else
  logic unused_flags;
  assign unused_flags = alu_zf ^ alu_of;
`endif
  assign last = cnt_q == 4'(EXEC_LAT - 1);
  always_comb begin
    state_d = state_q;
    view_d  = view_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
`ifdef ALU_SEQ_FLAGS_EN
    zf_d    = zf_q;
    of_d    = of_q;
`endif
    if (clr_p) begin
      state_d = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
    end else begin
      case (state_q)
        LOAD_A:  if (step_p) begin a_d = sw; state_d = LOAD_B; end
        LOAD_B:  if (step_p) begin b_d = sw; state_d = LOAD_OP; end
        LOAD_OP: if (step_p) begin op_d = sw[OP_W-1:0]; cnt_d = '0; state_d = EXEC; end
        EXEC: begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            f_d     = alu_f;
`ifdef ALU_SEQ_FLAGS_EN
            zf_d    = alu_zf;
            of_d    = alu_of;
`endif
            view_d  = V_F;
            state_d = SHOW;
          end
        end
        SHOW:    if (step_p) state_d = LOAD_A; else if (view_p) view_d = view_next(view_q);
        default: state_d = LOAD_A;
      endcase
    end
    // display follows the next state so SHOW shows the result from its first cycle
    disp_d = (state_d == LOAD_A || state_d == LOAD_B) ? sw :
             state_d == LOAD_OP ? {28'b0, sw[3:0]} :
             state_d == EXEC ? disp_q :
             view_d == V_A ? a_d : view_d == V_B ? b_d : f_d;
`ifdef ALU_SEQ_FLAGS_EN
    led_d = state_d == SHOW ? {zf_d, of_d, disp_d[29:0]} : disp_d;
`else
    led_d = disp_d;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      view_q  <= V_F;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      led_q   <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      view_q  <= view_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      led_q   <= led_d;
`ifdef ALU_SEQ_FLAGS_EN
      zf_q    <= zf_d;
      of_q    <= of_d;
`endif
    end
  end
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign disp_data = disp_q;
  assign led       = led_q;
  assign busy      = state_q == EXEC;
  assign stage     = state_q == LOAD_A ? 3'b001 : state_q == LOAD_B ? 3'b010 : state_q == LOAD_OP ? 3'b100 : 3'b000;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random button sequences checked against a behavioural model
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] sw = '0;
  logic btn_step = 1'b0, btn_clr = 1'b0, btn_view = 1'b0;
  logic [31:0] alu_a, alu_b, alu_f, disp_data, led;
  logic [3:0] alu_op;
  logic alu_zf, alu_of, busy;
  logic [2:0] stage;
  int vectors = 0, miscompares = 0, busy_cnt = 0;
  int mode, mview;
  logic [31:0] ma, mb, mf;
  logic [3:0] mop;
  logic mz, mo;

  alu_op_sequencer #(.DEBOUNCE_CYCLES(4), .EXEC_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_step(btn_step), .btn_clr(btn_clr), .btn_view(btn_view),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_f(alu_f), .alu_zf(alu_zf), .alu_of(alu_of),
    .disp_data(disp_data), .led(led), .stage(stage), .busy(busy)
  );

  always #25 clk = ~clk;
  always @(negedge clk) if (busy) busy_cnt++;

  function automatic logic [33:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [31:0] f;
    logic o;
    o = 1'b0;
    case (op)
      4'd0: begin f = a + b; o = (a[31] == b[31]) && (f[31] != a[31]); end
      4'd1: begin f = a - b; o = (a[31] != b[31]) && (f[31] != a[31]); end
      4'd2: f = a & b;
      4'd3: f = a | b;
      4'd4: f = a ^ b;
      default: f = a;
    endcase
    return {f == 32'd0, o, f};
  endfunction
  assign {alu_zf, alu_of, alu_f} = alu(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_disp();
    if (mode == 0 || mode == 1) return sw;
    if (mode == 2) return {28'b0, sw[3:0]};
    return mview == 1 ? ma : mview == 2 ? mb : mf;
  endfunction

  function automatic logic [31:0] exp_led();
    logic [31:0] d;
    d = exp_disp();
`ifdef ALU_SEQ_FLAGS_EN
    if (mode == 4) return {mz, mo, d[29:0]};
`endif
    return d;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".stage"}, 32'(stage), mode < 3 ? 32'(1 << mode) : 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".alu_a"}, alu_a, ma);
    chk({tag, ".alu_b"}, alu_b, mb);
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(mop));
    chk({tag, ".disp"}, disp_data, exp_disp());
    chk({tag, ".led"}, led, exp_led());
  endtask

  task automatic model_reset();
    mode = 0; mview = 0; ma = '0; mb = '0; mf = '0; mop = '0; mz = 1'b0; mo = 1'b0;
  endtask

  task automatic act(input bit s, input bit c, input bit v);
    btn_step = s; btn_clr = c; btn_view = v;
    repeat (10) @(posedge clk);
    btn_step = 1'b0; btn_clr = 1'b0; btn_view = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    if (c) begin
      mode = 0; ma = '0; mb = '0; mop = '0;
    end else if (s) begin
      case (mode)
        0: begin ma = sw; mode = 1; end
        1: begin mb = sw; mode = 2; end
        2: begin mop = sw[3:0]; {mz, mo, mf} = alu(ma, mb, mop); mview = 0; mode = 4; end
        default: mode = 0;
      endcase
    end else if (v && mode == 4) mview = (mview + 1) % 3;
  endtask

  initial begin
    int n;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3 check_all("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    sw = 32'h12345678;
    act(1, 0, 0);
    check_all("step_a");
    chk("step_a.value", alu_a, 32'h12345678);

    act(0, 1, 0);
    sw = 32'd7; act(1, 0, 0);
    sw = 32'd5; act(1, 0, 0);
    sw = 32'd0; busy_cnt = 0; act(1, 0, 0);
    chk("exec.busy_cycles", 32'(busy_cnt), 32'd3);
    chk("show.sum", disp_data, 32'd12);
    check_all("show");
    act(0, 0, 1); chk("view.a", disp_data, 32'd7);
    act(0, 0, 1); chk("view.b", disp_data, 32'd5);
    act(0, 0, 1); chk("view.f", disp_data, 32'd12);
    check_all("view");

    sw = $urandom;
    btn_step = 1'b1; @(posedge clk);
    btn_step = 1'b0; repeat (3) @(posedge clk);
    btn_step = 1'b1; repeat (2) @(posedge clk);
    btn_step = 1'b0; repeat (3) @(posedge clk);
    btn_step = 1'b1; @(posedge clk);
    btn_step = 1'b0; repeat (10) @(posedge clk);
    @(negedge clk);
    check_all("glitch");
    act(1, 0, 0);
    check_all("after_glitch");

    sw = $urandom; act(1, 0, 0);
    check_all("to_load_b");
    act(1, 1, 0);
    check_all("clr_wins");
    chk("clr_wins.a_zero", alu_a, 32'd0);

    repeat (60) begin
      int r;
      r = $urandom_range(0, 9);
      sw = $urandom;
      act(r <= 5 || r == 9, r >= 8, r == 6 || r == 7);
      check_all("rand");
    end

    act(0, 1, 0);
    sw = 32'd5; act(1, 0, 0);
    act(1, 0, 0);
    sw = 32'd1; act(1, 0, 0);
    check_all("zero_res");
    chk("zero_res.disp", disp_data, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("zero_res.led31", 32'(led[31]), 32'd1);
`endif

    act(0, 1, 0);
    sw = $urandom; act(1, 0, 0);
    sw = $urandom; act(1, 0, 0);
    sw = 32'd2;
    btn_step = 1'b1;
    n = 0;
    while (!busy && n < 40) begin @(negedge clk); n++; end
    btn_step = 1'b0;
    chk("exec_reached", 32'(busy), 32'd1);
    #5 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_exec.stage", 32'(stage), 32'd1);
    chk("rst_exec.busy", 32'(busy), 32'd0);
    chk("rst_exec.alu_a", alu_a, 32'd0);
    chk("rst_exec.alu_b", alu_b, 32'd0);
    chk("rst_exec.alu_op", 32'(alu_op), 32'd0);
    chk("rst_exec.disp", disp_data, 32'd0);
    chk("rst_exec.led", led, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_all("post_rst");
    act(1, 0, 0);
    act(1, 0, 0);
    act(0, 0, 1);
    check_all("post_rst_entry");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
